pwm_capture: RTL and testbench



---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_edge_det.sv | 60 ++++++
 rtl/pwm_capture.sv | 116 +++++++++++
 tb/tb_pwm_capture.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the PWM generator/capture pair
`timescale 1ns/1ps
package pwm_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int DUTY_W        = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/pwm_edge_det.sv
// rtl/pwm_edge_det.sv - pwm_in synchroniser and edge detector
// PWM_CAPTURE_DEGLITCH_EN inserts a 3-sample majority filter that drops 1-cycle pulses.
`timescale 1ns/1ps
module pwm_edge_det
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pwm_in,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], pwm_in};
    end
  end

`ifdef PWM_CAPTURE_DEGLITCH_EN
  // Filtered level only moves once two of the last three samples agree,
  // so both edges of an accepted pulse see the same extra delay.
  logic [1:0] hist;
  logic       filt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      filt <= 1'b0;
    end else begin
      hist <= {hist[0], sync_ff[SYNC_STAGES-1]};
      filt <= majority3(sync_ff[SYNC_STAGES-1], hist[0], hist[1]);
    end
  end

  assign sync = filt;
`else
  assign sync = sync_ff[SYNC_STAGES-1];
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev <= 1'b0;
    end else begin
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures high time and period of an incoming PWM waveform
// Build with PWM_CAPTURE_DEGLITCH_EN to filter pulses shorter than 2 cycles.
`timescale 1ns/1ps
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  logic             sync;
  logic             rise;
  logic             fall;
  pwm_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_lat;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_tmo;

  pwm_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_det (
    .clock   (clock),
    .reset_n (reset_n),
    .pwm_in  (pwm_in),
    .sync    (sync),
    .rise    (rise),
    .fall    (fall)
  );

  // cnt holds cycles since the last rise detection and sticks at TMO
  assign at_tmo  = (cnt >= TMO);
  assign cnt_inc = at_tmo ? TMO : cnt + CNT_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hi_lat      <= '0;
      high_time   <= '0;
      period      <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        state  <= IDLE;
        cnt    <= '0;
        hi_lat <= '0;
      end else begin
        if (stuck && (rise || fall)) begin
          stuck       <= 1'b0;
          stuck_level <= 1'b0;
        end
        case (state)
          IDLE: begin
            if (rise) begin
              cnt   <= CNT_W'(1);
              state <= HIGH;
            end
          end
          HIGH: begin
            if (fall) begin
              hi_lat <= cnt;
              cnt    <= cnt_inc;
              state  <= LOW;
            end else if (at_tmo) begin
              stuck       <= 1'b1;
              stuck_level <= sync;
              cnt         <= '0;
              state       <= IDLE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          LOW: begin
            // an edge on the timeout cycle still completes the period
            if (rise) begin
              high_time  <= hi_lat;
              period     <= cnt;
              meas_valid <= 1'b1;
              cnt        <= CNT_W'(1);
              state      <= HIGH;
            end else if (at_tmo) begin
              stuck       <= 1'b1;
              stuck_level <= sync;
              cnt         <= '0;
              state       <= IDLE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - randomized self-checking bench for pwm_capture
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int CNT_W       = 16;
  localparam int SS          = 2;
  localparam int TIMEOUT     = 1000;
`ifdef PWM_CAPTURE_DEGLITCH_EN
  localparam bit DEGLITCH = 1'b1;
`else
  localparam bit DEGLITCH = 1'b0;
`endif

  logic             clock   = 1'b0;
  logic             reset_n = 1'b1;
  logic             enable  = 1'b0;
  logic             pwm_in  = 1'b0;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] period;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;

  int n_checks = 0;
  int n_fails  = 0;
  int mv_count = 0;
  int mv_base  = 0;
  int last_ht  = 0;
  int last_per = 0;

  pwm_capture #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SS),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .pwm_in      (pwm_in),
    .high_time   (high_time),
    .period      (period),
    .meas_valid  (meas_valid),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  always #5 clock = ~clock;

  // Reference model: detected level is the input delayed by the synchroniser
  // (majority of three when filtering); measurements use rise/fall timestamps.
  logic [7:0]       s_hist = '0;
  logic             m_cur, m_prv, m_rise, m_fall;
  bit               armed = 0, in_low = 0;
  int               k = 0, k_r = 0, k_f = 0, elapsed = 0;
  logic [CNT_W-1:0] e_ht = '0, e_per = '0;
  logic             e_mv = 1'b0, e_stuck = 1'b0, e_sl = 1'b0;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic int sat(input int v);
    return (v > TIMEOUT) ? TIMEOUT : v;
  endfunction

  initial begin
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        s_hist = '0; armed = 0; in_low = 0; k = 0; k_r = 0; k_f = 0;
        e_ht = '0; e_per = '0; e_mv = 1'b0; e_stuck = 1'b0; e_sl = 1'b0;
      end else begin
        s_hist = {s_hist[6:0], pwm_in};
        if (DEGLITCH) begin
          m_cur = maj(s_hist[SS+1], s_hist[SS+2], s_hist[SS+3]);
          m_prv = maj(s_hist[SS+2], s_hist[SS+3], s_hist[SS+4]);
        end else begin
          m_cur = s_hist[SS];
          m_prv = s_hist[SS+1];
        end
        m_rise = m_cur & ~m_prv;
        m_fall = ~m_cur & m_prv;
        e_mv = 1'b0;
        if (!enable) begin
          armed = 0;
        end else begin
          if (e_stuck && (m_rise || m_fall)) begin
            e_stuck = 1'b0;
            e_sl    = 1'b0;
          end
          elapsed = k - k_r;
          if (!armed) begin
            if (m_rise) begin armed = 1; in_low = 0; k_r = k; end
          end else if (!in_low) begin
            if (m_fall) begin
              in_low = 1; k_f = k;
            end else if (elapsed >= TIMEOUT) begin
              e_stuck = 1'b1; e_sl = m_cur; armed = 0;
            end
          end else begin
            if (m_rise) begin
              e_ht  = CNT_W'(sat(k_f - k_r));
              e_per = CNT_W'(sat(elapsed));
              e_mv  = 1'b1;
              k_r   = k;
              in_low = 0;
            end else if (elapsed >= TIMEOUT) begin
              e_stuck = 1'b1; e_sl = m_cur; armed = 0;
            end
          end
        end
        k++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (meas_valid) begin
        mv_count++;
        last_ht  = int'(high_time);
        last_per = int'(period);
      end
      n_checks++;
      if ({high_time, period, meas_valid, stuck, stuck_level} !==
          {e_ht, e_per, e_mv, e_stuck, e_sl}) begin
        n_fails++;
        $display("FAIL cycle_model t=%0t: dut ht=%0d per=%0d mv=%0b stuck=%0b lvl=%0b, model ht=%0d per=%0d mv=%0b stuck=%0b lvl=%0b",
                 $time, high_time, period, meas_valid, stuck, stuck_level,
                 e_ht, e_per, e_mv, e_stuck, e_sl);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int len;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_high_time", high_time, 0);
    check("reset_period", period, 0);
    check("reset_meas_valid", meas_valid, 0);
    check("reset_stuck", stuck, 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    drive(0, 20);

    // 100 high / 156 low, four times
    mv_base = mv_count;
    repeat (4) begin drive(1, 100); drive(0, 156); end
    check("basic_valid_count", mv_count - mv_base, 3);
    check("basic_high_time", last_ht, 100);
    check("basic_period", last_per, 256);

    // input held low past the timeout
    mv_base = mv_count;
    drive(0, TIMEOUT + 200);
    check("stuck_set", stuck, 1);
    check("stuck_level_low", stuck_level, 0);
    check("stuck_no_valid", mv_count - mv_base, 0);
    drive(1, 10);
    check("stuck_cleared", stuck, 0);
    drive(0, 10);

    // 50/50 waveform with enable dropped mid-high
    repeat (5) begin drive(1, 5); drive(0, 5); end
    check("half_high_time", high_time, 5);
    check("half_period", period, 10);
    drive(1, 5); drive(0, 1);
    enable = 1'b0;
    drive(0, 4);
    mv_base = mv_count;
    repeat (3) begin drive(1, 5); drive(0, 5); end
    check("dis_no_valid", mv_count - mv_base, 0);
    check("dis_hold_high_time", high_time, 5);
    check("dis_hold_period", period, 10);
    enable = 1'b1;
    mv_base = mv_count;
    drive(1, 5); drive(0, 5);
    check("reen_first_rise_no_valid", mv_count - mv_base, 0);
    drive(1, 5); drive(0, 5);
    check("reen_second_rise_valid", mv_count - mv_base, 1);
    check("reen_period", last_per, 10);

    // 1-cycle glitch every 20 cycles
    mv_base = mv_count;
    repeat (60) begin drive(1, 1); drive(0, 19); end
`ifdef PWM_CAPTURE_DEGLITCH_EN
    check("glitch_no_valid", mv_count - mv_base, 0);
    check("glitch_stuck", stuck, 1);
`else
    check("glitch_high_time", high_time, 1);
    check("glitch_period", period, 20);
    check("glitch_not_stuck", stuck, 0);
`endif

    // rise exactly on the timeout cycle, then one cycle late
    drive(1, 50); drive(0, TIMEOUT - 50); drive(1, 50); drive(0, 50);
    check("tmo_edge_period", last_per, TIMEOUT);
    check("tmo_edge_high_time", last_ht, 50);
    check("tmo_edge_not_stuck", stuck, 0);
    drive(0, TIMEOUT - 99); drive(1, 20); drive(0, 20);

    // asynchronous reset during a high phase
    drive(1, 10);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_high_time", high_time, 0);
    check("async_reset_period", period, 0);
    check("async_reset_stuck", stuck, 0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(1, 10);
    repeat (3) begin drive(0, 20); drive(1, 20); end
    drive(0, 20);

    // randomized segments with occasional enable toggles
    repeat (300) begin
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      len = int'($urandom_range(1, 30));
      if ($urandom_range(0, 59) == 0) len = TIMEOUT - 5 + int'($urandom_range(0, 10));
      drive(1'($urandom_range(0, 1)), len);
    end
    enable = 1'b1;
    drive(0, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
